disp_scheduler: RTL and testbench

DISP_SCHEDULER -- requirements
Module: disp_scheduler

---
 rtl/disp_if.sv | 15 +
 rtl/disp_scheduler.sv | 88 ++++++++
 tb/tb_disp_scheduler.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/disp_if.sv
// disp_if: back-buffer write/commit handshake between a host (master) and disp_scheduler (slave).
//   wr_valid  host -> sched  character write request
//   wr_addr   host -> sched  digit index 0..11 (12..15 accepted and discarded)
//   wr_data   host -> sched  14-segment pattern
//   wr_commit host -> sched  request back-to-front swap at the next frame end
//   wr_ready  sched -> host  write/commit accepted this cycle when high
interface disp_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [13:0] wr_data;
    logic        wr_commit;
    modport master (output wr_valid, wr_addr, wr_data, wr_commit, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, wr_commit, output wr_ready);
endinterface

// File: rtl/disp_scheduler.sv
// disp_scheduler: double-buffered 12-digit 14-segment multiplexed display scanner.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         disp_if.slave write/commit port
//   blank       forces sel/segm dark from the next cycle; scanning continues
//   sel         one-hot digit select (registered)
//   segm        segment pattern for the selected digit (registered)
//   frame_tick  one-cycle pulse in the last cycle of each 12-digit frame
//   scroll_en   only with DISP_SCROLL_EN: advance the display offset every frame
// Macro DISP_SCROLL_EN enables the rotating offset; undefined means offset fixed at 0.
module disp_scheduler #(
    parameter int DIV = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    disp_if.slave       bus,
    input  logic        blank,
    output logic [11:0] sel,
    output logic [13:0] segm,
    output logic        frame_tick
`ifdef DISP_SCROLL_EN
    ,
    input  logic        scroll_en
`endif
);
    typedef enum logic {RUN, PEND} state_t;
    state_t      state_q, state_d;
    logic [15:0] pre;
    logic [3:0]  digit, offset, ofs_d, idx;
    logic [4:0]  sum;
    logic        rdy_q, pre_last, wr_acc, swap;
    logic [13:0] front [12];
    logic [13:0] back  [12];

    assign pre_last     = pre == 16'(DIV - 1);
    assign frame_tick   = pre_last && digit == 4'd11;
    // rdy_q keeps wr_ready low until the first edge after reset release
    assign bus.wr_ready = rdy_q && state_q == RUN;
    assign wr_acc       = bus.wr_valid && bus.wr_ready;
    assign swap         = state_q == PEND && frame_tick;
    assign sum          = {1'b0, digit} + {1'b0, offset};
    assign idx          = sum >= 5'd12 ? 4'(sum - 5'd12) : sum[3:0];

    always_comb begin
        state_d = state_q;
        ofs_d   = offset;
        if (state_q == RUN)
            state_d = (bus.wr_commit && bus.wr_ready) ? PEND : RUN;
        else
            state_d = frame_tick ? RUN : PEND;
`ifdef DISP_SCROLL_EN
        if (frame_tick && scroll_en)
            ofs_d = offset == 4'd11 ? 4'd0 : offset + 4'd1;
`else
        ofs_d = 4'd0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pre     <= '0;
            digit   <= '0;
            offset  <= '0;
            rdy_q   <= 1'b0;
            sel     <= '0;
            segm    <= '0;
            for (int i = 0; i < 12; i++) begin
                front[i] <= '0;
                back[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            offset  <= ofs_d;
            rdy_q   <= 1'b1;
            pre     <= pre_last ? '0 : pre + 16'd1;
            if (pre_last)
                digit <= digit == 4'd11 ? 4'd0 : digit + 4'd1;
            sel  <= blank ? '0 : 12'(1) << digit;
            segm <= blank ? '0 : front[idx];
            // writes only happen in RUN and swaps only in PEND, so they never collide
            if (wr_acc && bus.wr_addr <= 4'd11)
                back[bus.wr_addr] <= bus.wr_data;
            // swap lands on the frame boundary, so digit 0 of the next frame sees the new front
            if (swap)
                front <= back;
        end
    end
endmodule

// File: tb/tb_disp_scheduler.sv
// tb_disp_scheduler: directed self-checking bench for disp_scheduler with DIV = 4.
module tb_disp_scheduler;
    localparam int DIV = 4;
    logic        clk = 0, rst_n = 0, blank = 0, scroll_en = 0;
    logic [11:0] sel;
    logic [13:0] segm;
    logic        frame_tick;
    logic [13:0] exp_front [12];
    int          checks = 0, failures = 0, cyc = 0;
    bit          chk_seg = 1;

    disp_if bus ();

    disp_scheduler #(.DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .blank      (blank),
        .sel        (sel),
        .segm       (segm),
        .frame_tick (frame_tick)
`ifdef DISP_SCROLL_EN
        ,
        .scroll_en  (scroll_en)
`endif
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // after edge n: sel shows digit (n-1)/4 mod 12, frame_tick high when n mod 48 == 47
    task automatic tick_chk();
        logic b;
        int   d;
        b = blank;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        d = ((cyc - 1) / 4) % 12;
        check("sel", 32'(sel), b ? 32'd0 : 32'(1) << d);
        if (chk_seg)
            check("segm", 32'(segm), b ? 32'd0 : 32'(exp_front[d]));
        check("frame_tick", 32'(frame_tick), 32'((cyc % 48) == 47));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 0;
        #1;
        for (int i = 0; i < 12; i++) exp_front[i] = '0;
        check("rst_ready", 32'(bus.wr_ready), 0);
        check("rst_sel", 32'(sel), 0);
        check("rst_segm", 32'(segm), 0);
        check("rst_ft", 32'(frame_tick), 0);
        @(negedge clk);
        rst_n = 1;
        cyc   = 0;
        check("rel_ready_low", 32'(bus.wr_ready), 0);
        tick_chk();
        check("rel_ready", 32'(bus.wr_ready), 1);
    endtask

    task automatic write(input logic [3:0] a, input logic [13:0] d);
        bus.wr_valid = 1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        check("wr_ready_wr", 32'(bus.wr_ready), 1);
        tick_chk();
        bus.wr_valid = 0;
    endtask

    task automatic commit();
        bus.wr_commit = 1;
        check("wr_ready_commit", 32'(bus.wr_ready), 1);
        tick_chk();
        bus.wr_commit = 0;
    endtask

    // ready must stay low through the frame end; the edge after frame_tick swaps
    task automatic wait_swap();
        int n = 0;
        while (!frame_tick && n < 60) begin
            check("ready_pend", 32'(bus.wr_ready), 0);
            tick_chk();
            n++;
        end
        check("swap_ft_seen", 32'(frame_tick), 1);
        check("ready_pend_ft", 32'(bus.wr_ready), 0);
        tick_chk();
        check("ready_after_swap", 32'(bus.wr_ready), 1);
    endtask

    initial begin
        bus.wr_valid  = 0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.wr_commit = 0;
        do_reset();
        repeat (96) tick_chk();

        repeat (10) tick_chk();
        write(4'd0, 14'h3BC0);
        write(4'd9, 14'h2F40);
        commit();
        wait_swap();
        exp_front[0] = 14'h3BC0;
        exp_front[9] = 14'h2F40;
        repeat (48) tick_chk();

        write(4'd13, 14'h3FFF);
        commit();
        wait_swap();
        repeat (48) tick_chk();

        bus.wr_valid  = 1;
        bus.wr_addr   = 4'd2;
        bus.wr_data   = 14'h2780;
        bus.wr_commit = 1;
        check("ready_wr_commit", 32'(bus.wr_ready), 1);
        tick_chk();
        bus.wr_valid  = 0;
        bus.wr_commit = 0;
        wait_swap();
        exp_front[2] = 14'h2780;
        repeat (48) tick_chk();

        repeat (5) tick_chk();
        blank = 1;
        repeat (10) tick_chk();
        blank = 0;
        repeat (20) tick_chk();

        while (!frame_tick && cyc < 2000) tick_chk();
        check("ft_for_commit", 32'(frame_tick), 1);
        bus.wr_valid  = 1;
        bus.wr_addr   = 4'd5;
        bus.wr_data   = 14'h1555;
        bus.wr_commit = 1;
        check("ready_ft_commit", 32'(bus.wr_ready), 1);
        tick_chk();
        bus.wr_valid  = 0;
        bus.wr_commit = 0;
        wait_swap();
        exp_front[5] = 14'h1555;
        repeat (48) tick_chk();

        write(4'd1, 14'h0ABC);
        commit();
        repeat (5) tick_chk();
        check("pend_before_rst", 32'(bus.wr_ready), 0);
        do_reset();
        repeat (60) tick_chk();
        check("ready_after_pend_rst", 32'(bus.wr_ready), 1);

`ifdef DISP_SCROLL_EN
        scroll_en = 1;
        do_reset();
        chk_seg = 0;
        write(4'd0, 14'h3BC0);
        commit();
        while (cyc < 49) tick_chk();
        check("scroll_f2_d0", 32'(segm), 0);
        while (cyc < 93) tick_chk();
        check("scroll_f2_d11", 32'(segm), 32'h3BC0);
        while (cyc < 137) tick_chk();
        check("scroll_f3_d10", 32'(segm), 32'h3BC0);
        scroll_en = 0;
        while (cyc < 185) tick_chk();
        check("scroll_freeze_d10", 32'(segm), 32'h3BC0);
        chk_seg = 1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
